spi_crc_tx: RTL

SPI responder-side transmitter: serialises a byte stream onto miso, MSB-first, one bit per rising spi_clk edge, then appends a 16-bit CRC.
- CRC is CRC-16/XMODEM: poly 0x1021, init 0x0000, no reflection, no final XOR.
- CRC is computed on the fly over the transmitted data bits.
- Pairs with the receive-side CRC checker on the mosi path, giving symmetric CRC-protected block transfers to and from the cart.

---
 rtl/crc_pkg.sv | 17 +
 rtl/crc16_serial_step.sv | 14 +
 rtl/spi_crc_tx.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/crc_pkg.sv
// Shared CRC-16/XMODEM constants and SPI transmit state encodings.
// START_TOKEN_EN builds add the TOKEN state to the transmitter.
package crc_pkg;

  localparam logic [15:0] CRC16_POLY   = 16'h1021;
  localparam logic [15:0] CRC16_INIT   = 16'h0000;
  localparam logic [7:0]  START_TOKEN  = 8'hFE;
  localparam logic [7:0]  DEFAULT_FILL = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    CRC   = 2'd2,
    TOKEN = 2'd3
  } tx_state_e;

endpackage

// File: rtl/crc16_serial_step.sv
// One-bit CRC-16 update, MSB-first, no reflection.
// Also used by the mosi-side checker.
module crc16_serial_step
  import crc_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic        bit_in,
  output logic [15:0] crc_out
);

  assign crc_out = {crc_in[14:0], 1'b0}
                 ^ ((crc_in[15] ^ bit_in) ? CRC16_POLY : 16'h0000);

endmodule

// File: rtl/spi_crc_tx.sv
// SPI responder transmitter: MSB-first bytes on miso plus CRC-16/XMODEM.
// Optional macro START_TOKEN_EN prefixes each block with token 0xFE.
module spi_crc_tx
  import crc_pkg::*;
#(
  parameter logic [15:0] CRC_INIT  = CRC16_INIT,
  parameter logic [7:0]  FILL_BYTE = DEFAULT_FILL
) (
  input  logic        spi_clk,
  input  logic        reset,
  input  logic        en,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  input  logic        tx_last,
  output logic        tx_ready,
  output logic        miso,
  output logic        busy,
  output logic        done,
  output logic        underrun,
  output logic [15:0] crc16
);

  tx_state_e   state_q, state_d;
  logic [7:0]  sh_q, sh_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic [15:0] crc_q, crc_d;
  logic [15:0] crs_q, crs_d;
  logic        miso_q, miso_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        urun_q, urun_d;
  logic [15:0] crc16_q, crc16_d;
`ifdef START_TOKEN_EN
  logic [7:0]  hold_q, hold_d;
`endif

  logic [7:0]  ld_byte;
  logic        step_bit;
  logic [15:0] step_crc;
  logic [15:0] crc_nxt;
  logic        accept;

  assign tx_ready = en & ((state_q == IDLE)
                  | ((state_q == DATA) & (cnt_q == 4'd0) & ~last_q));
  assign accept   = tx_ready & tx_valid;

  assign miso     = miso_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign underrun = urun_q;
  assign crc16    = crc16_q;

  // Bit entering the CRC: top of a freshly loaded byte, else next shifted bit
  always_comb begin
    ld_byte = tx_valid ? tx_data : FILL_BYTE;
`ifdef START_TOKEN_EN
    if (state_q == TOKEN) ld_byte = hold_q;
`endif
    step_bit = sh_q[7];
    if (state_q == IDLE || cnt_q == 4'd0) step_bit = ld_byte[7];
    step_crc = (state_q == IDLE) ? CRC_INIT : crc_q;
  end

  crc16_serial_step u_step (
    .crc_in  (step_crc),
    .bit_in  (step_bit),
    .crc_out (crc_nxt)
  );

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    crc_d   = crc_q;
    crs_d   = crs_q;
    miso_d  = miso_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    urun_d  = urun_q;
    crc16_d = crc16_q;
`ifdef START_TOKEN_EN
    hold_d  = hold_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          busy_d = 1'b1;
          urun_d = 1'b0;
          last_d = tx_last;
          cnt_d  = 4'd7;
`ifdef START_TOKEN_EN
          hold_d  = tx_data;
          sh_d    = {START_TOKEN[6:0], 1'b0};
          miso_d  = START_TOKEN[7];
          crc_d   = CRC_INIT;
          state_d = TOKEN;
`else
          sh_d    = {tx_data[6:0], 1'b0};
          miso_d  = tx_data[7];
          crc_d   = crc_nxt;
          state_d = DATA;
`endif
        end
      end
`ifdef START_TOKEN_EN
      TOKEN: begin
        if (cnt_q == 4'd0) begin
          sh_d    = {hold_q[6:0], 1'b0};
          miso_d  = hold_q[7];
          crc_d   = crc_nxt;
          cnt_d   = 4'd7;
          state_d = DATA;
        end else begin
          sh_d   = {sh_q[6:0], 1'b0};
          miso_d = sh_q[7];
          cnt_d  = cnt_q - 4'd1;
        end
      end
`endif
      DATA: begin
        if (cnt_q != 4'd0) begin
          sh_d   = {sh_q[6:0], 1'b0};
          miso_d = sh_q[7];
          crc_d  = crc_nxt;
          cnt_d  = cnt_q - 4'd1;
        end else if (last_q) begin
          crc16_d = crc_q;
          miso_d  = crc_q[15];
          crs_d   = {crc_q[14:0], 1'b0};
          cnt_d   = 4'd15;
          state_d = CRC;
        end else begin
          // Fill bytes never end a block, whatever tx_last says
          sh_d   = {ld_byte[6:0], 1'b0};
          miso_d = ld_byte[7];
          crc_d  = crc_nxt;
          cnt_d  = 4'd7;
          last_d = tx_valid & tx_last;
          if (!tx_valid) urun_d = 1'b1;
        end
      end
      CRC: begin
        if (cnt_q != 4'd0) begin
          miso_d = crs_q[15];
          crs_d  = {crs_q[14:0], 1'b0};
          cnt_d  = cnt_q - 4'd1;
        end else begin
          miso_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge spi_clk) begin
    if (reset)   state_q <= IDLE;
    else if (en) state_q <= state_d;
  end

  always_ff @(posedge spi_clk) begin
    if (reset) begin
      sh_q    <= 8'h00;
      cnt_q   <= 4'd0;
      last_q  <= 1'b0;
      crc_q   <= CRC_INIT;
      crs_q   <= 16'h0000;
      miso_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      urun_q  <= 1'b0;
      crc16_q <= 16'h0000;
`ifdef START_TOKEN_EN
      hold_q  <= 8'h00;
`endif
    end else if (en) begin
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      crc_q   <= crc_d;
      crs_q   <= crs_d;
      miso_q  <= miso_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      urun_q  <= urun_d;
      crc16_q <= crc16_d;
`ifdef START_TOKEN_EN
      hold_q  <= hold_d;
`endif
    end
  end

endmodule
